// File: rtl/l1c_axi_pkg.sv
// Shared definitions for the L1 data-cache to AXI4 bridge: FSM states,
// AXI encodings and the cache access-size codes carried on D_type.
package l1c_axi_pkg;

    // Width and encodings of the cache access-size field (D_type).
    localparam int CACHE_TYPE_BITS = 3;
    localparam logic [CACHE_TYPE_BITS-1:0] CACHE_BYTE    = 3'd0;
    localparam logic [CACHE_TYPE_BITS-1:0] CACHE_HWORD   = 3'd1;
    localparam logic [CACHE_TYPE_BITS-1:0] CACHE_WORD    = 3'd2;
    localparam logic [CACHE_TYPE_BITS-1:0] CACHE_BYTE_U  = 3'd4;
    localparam logic [CACHE_TYPE_BITS-1:0] CACHE_HWORD_U = 3'd5;

    // AXI4 encodings used by the bridge.
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_WORD  = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RADDR,
        ST_RDATA,
        ST_RACK,
        ST_WREQ,
        ST_WRESP,
        ST_WACK
    } state_t;

endpackage

// File: rtl/l1c_wstrb_gen.sv
// Byte-lane strobe generator: maps the cache access size and the low
// address bits onto the 4-bit AXI write strobe. Unknown sizes write nothing.
module l1c_wstrb_gen
    import l1c_axi_pkg::*;
(
    input  logic [CACHE_TYPE_BITS-1:0] d_type,
    input  logic [1:0]                 addr_lo,
    output logic [3:0]                 wstrb
);

    // Pure decode of size + lane offset.
    always_comb begin
        wstrb = 4'b0000;
        case (d_type)
            CACHE_WORD:                 wstrb = 4'b1111;
            CACHE_HWORD, CACHE_HWORD_U: wstrb = 4'b0011 << {addr_lo[1], 1'b0};
            CACHE_BYTE, CACHE_BYTE_U:   wstrb = 4'b0001 << addr_lo;
            default:                    wstrb = 4'b0000;
        endcase
    end

endmodule

// File: rtl/l1c_axi_bridge.sv
// L1 data-cache memory responder. Line reads become one BURST_LEN-beat AXI4
// INCR burst, handed back one word per D_wait-low cycle; writes become one
// single-beat AXI4 write acknowledged after the B response.
// Optional build macro L1C_AXI_BRIDGE_ERR_EN adds a sticky error flag
// (err_o) and the address of the first transaction with a non-OKAY response.
module l1c_axi_bridge
    import l1c_axi_pkg::*;
#(
    parameter logic [3:0] AXI_ID    = 4'd0,
    parameter int         BURST_LEN = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       D_req,
    input  logic [31:0]                D_addr,
    input  logic                       D_write,
    input  logic [31:0]                D_in,
    input  logic [CACHE_TYPE_BITS-1:0] D_type,
    output logic [31:0]                D_out,
    output logic                       D_wait,
    output logic [3:0]                 ARID,
    output logic [31:0]                ARADDR,
    output logic [3:0]                 ARLEN,
    output logic [2:0]                 ARSIZE,
    output logic [1:0]                 ARBURST,
    output logic                       ARVALID,
    input  logic                       ARREADY,
    input  logic [3:0]                 RID,
    input  logic [31:0]                RDATA,
    input  logic [1:0]                 RRESP,
    input  logic                       RLAST,
    input  logic                       RVALID,
    output logic                       RREADY,
    output logic [3:0]                 AWID,
    output logic [31:0]                AWADDR,
    output logic [3:0]                 AWLEN,
    output logic [2:0]                 AWSIZE,
    output logic [1:0]                 AWBURST,
    output logic                       AWVALID,
    input  logic                       AWREADY,
    output logic [31:0]                WDATA,
    output logic [3:0]                 WSTRB,
    output logic                       WLAST,
    output logic                       WVALID,
    input  logic                       WREADY,
    input  logic [3:0]                 BID,
    input  logic [1:0]                 BRESP,
    input  logic                       BVALID,
    output logic                       BREADY
`ifdef L1C_AXI_BRIDGE_ERR_EN
    ,
    output logic                       err_o,
    output logic [31:0]                err_addr
`endif
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN);

    state_t           state_reg, state_next;
    logic [31:0]      addr_reg, addr_next;
    logic [31:0]      data_reg, data_next;
    logic [3:0]       strb_reg, strb_next;
    logic [31:0]      d_out_reg, d_out_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             aw_done_reg, aw_done_next;
    logic             w_done_reg, w_done_next;
    logic             aw_ok, w_ok;
    logic             ack;
    logic [3:0]       wstrb_calc;

    // IDs, RLAST and the ID/response fields of the return channels carry no
    // information the bridge needs: the beat counter alone ends a burst.
    logic unused_inputs;
    assign unused_inputs = ^{RID, RLAST, BID, RRESP, BRESP};

    l1c_wstrb_gen u_wstrb (
        .d_type  (D_type),
        .addr_lo (D_addr[1:0]),
        .wstrb   (wstrb_calc)
    );

    // Fixed AXI attributes and the latched transaction payload.
    assign ARID    = AXI_ID;
    assign ARADDR  = addr_reg;
    assign ARLEN   = 4'(BURST_LEN - 1);
    assign ARSIZE  = SIZE_WORD;
    assign ARBURST = BURST_INCR;
    assign AWID    = AXI_ID;
    assign AWADDR  = addr_reg;
    assign AWLEN   = 4'd0;
    assign AWSIZE  = SIZE_WORD;
    assign AWBURST = BURST_INCR;
    assign WDATA   = data_reg;
    assign WSTRB   = strb_reg;
    assign WLAST   = 1'b1;
    assign D_out   = d_out_reg;
    // A dropped request suppresses the acknowledge of a transaction in flight.
    assign D_wait  = D_req & ~ack;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            addr_reg    <= '0;
            data_reg    <= '0;
            strb_reg    <= '0;
            d_out_reg   <= '0;
            cnt_reg     <= '0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            addr_reg    <= addr_next;
            data_reg    <= data_next;
            strb_reg    <= strb_next;
            d_out_reg   <= d_out_next;
            cnt_reg     <= cnt_next;
            aw_done_reg <= aw_done_next;
            w_done_reg  <= w_done_next;
        end
    end

    // Next-state logic and the Moore handshake outputs.
    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        data_next    = data_reg;
        strb_next    = strb_reg;
        d_out_next   = d_out_reg;
        cnt_next     = cnt_reg;
        aw_done_next = aw_done_reg;
        w_done_next  = w_done_reg;
        aw_ok        = 1'b0;
        w_ok         = 1'b0;
        ARVALID      = 1'b0;
        RREADY       = 1'b0;
        AWVALID      = 1'b0;
        WVALID       = 1'b0;
        BREADY       = 1'b0;
        ack          = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (D_req) begin
                    if (D_write) begin
                        state_next = ST_WREQ;
                        addr_next  = D_addr;
                        data_next  = D_in;
                        strb_next  = wstrb_calc;
                    end else begin
                        state_next = ST_RADDR;
                        addr_next  = {D_addr[31:4], 4'b0000};
                    end
                end
            end
            ST_RADDR: begin
                ARVALID = 1'b1;
                if (ARREADY) state_next = ST_RDATA;
            end
            ST_RDATA: begin
                RREADY = 1'b1;
                if (RVALID) begin
                    d_out_next = RDATA;
                    cnt_next   = cnt_reg + CNT_W'(1);
                    state_next = ST_RACK;
                end
            end
            ST_RACK: begin
                ack = 1'b1;
                if (cnt_reg == LAST_CNT) begin
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_RDATA;
                end
            end
            ST_WREQ: begin
                // AW and W complete independently; each VALID drops on its own handshake.
                AWVALID      = ~aw_done_reg;
                WVALID       = ~w_done_reg;
                aw_ok        = aw_done_reg | AWREADY;
                w_ok         = w_done_reg | WREADY;
                aw_done_next = aw_ok;
                w_done_next  = w_ok;
                if (aw_ok && w_ok) begin
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                    state_next   = ST_WRESP;
                end
            end
            ST_WRESP: begin
                BREADY = 1'b1;
                if (BVALID) state_next = ST_WACK;
            end
            ST_WACK: begin
                ack        = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

`ifdef L1C_AXI_BRIDGE_ERR_EN
    logic        err_reg;
    logic [31:0] err_addr_reg;

    // Capture the first non-OKAY read or write response; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_reg      <= 1'b0;
            err_addr_reg <= '0;
        end else if (!err_reg &&
                     ((RVALID && RREADY && RRESP != RESP_OKAY) ||
                      (BVALID && BREADY && BRESP != RESP_OKAY))) begin
            err_reg      <= 1'b1;
            err_addr_reg <= addr_reg;
        end
    end

    assign err_o    = err_reg;
    assign err_addr = err_addr_reg;
`endif

endmodule

// File: tb/tb_l1c_axi_bridge.sv
// Self-checking bench for l1c_axi_bridge: a directed vector table followed by
// randomized transactions, with an AXI slave and expected values kept here.
module tb_l1c_axi_bridge;
    import l1c_axi_pkg::*;

    localparam int BURST = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        D_req, D_write, D_wait;
    logic [31:0] D_addr, D_in, D_out;
    logic [2:0]  D_type;
    logic [3:0]  ARID, ARLEN, AWID, AWLEN, WSTRB, RID, BID;
    logic [31:0] ARADDR, AWADDR, WDATA, RDATA;
    logic [2:0]  ARSIZE, AWSIZE;
    logic [1:0]  ARBURST, unused_awburst, RRESP, BRESP;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
`ifdef L1C_AXI_BRIDGE_ERR_EN
    logic        err_o;
    logic [31:0] err_addr;
`endif

    always #5 clk = ~clk;

    l1c_axi_bridge #(.AXI_ID(4'd0), .BURST_LEN(BURST)) dut (
        .clk(clk), .rst(rst),
        .D_req(D_req), .D_addr(D_addr), .D_write(D_write), .D_in(D_in), .D_type(D_type),
        .D_out(D_out), .D_wait(D_wait),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(unused_awburst),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
`ifdef L1C_AXI_BRIDGE_ERR_EN
        ,
        .err_o(err_o), .err_addr(err_addr)
`endif
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  typ;
        logic [31:0] din;
        logic [31:0] rbase;
        int          ar_dly, aw_dly, w_dly, b_dly;
        int          gap_beat, gap_len, rst_after;
        logic [1:0]  resp;
        bit          rlast_rand;
        logic [31:0] exp_axaddr;
        logic [3:0]  exp_strb;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference strobe rule: byte lanes touched by an access of the given size.
    function automatic logic [3:0] model_strb(input logic [2:0] t, input logic [31:0] a);
        int lane;
        lane = int'(a % 32'd4);
        case (t)
            CACHE_WORD:                 return 4'hF;
            CACHE_HWORD, CACHE_HWORD_U: return (lane >= 2) ? 4'b1100 : 4'b0011;
            CACHE_BYTE, CACHE_BYTE_U:   return 4'(1 << lane);
            default:                    return 4'h0;
        endcase
    endfunction

    function automatic vec_t rd_vec(input logic [31:0] addr, input logic [31:0] rbase,
                                    input logic [31:0] exp_axaddr);
        vec_t v;
        v.wr = 1'b0; v.addr = addr; v.typ = CACHE_WORD; v.din = '0; v.rbase = rbase;
        v.ar_dly = 0; v.aw_dly = 0; v.w_dly = 0; v.b_dly = 0;
        v.gap_beat = 0; v.gap_len = 0; v.rst_after = 0;
        v.resp = RESP_OKAY; v.rlast_rand = 1'b0;
        v.exp_axaddr = exp_axaddr; v.exp_strb = '0;
        return v;
    endfunction

    function automatic vec_t wr_vec(input logic [31:0] addr, input logic [2:0] typ,
                                    input logic [31:0] din, input int aw_dly, input int w_dly,
                                    input int b_dly, input logic [1:0] resp,
                                    input logic [3:0] exp_strb);
        vec_t v;
        v = rd_vec(addr, '0, addr);
        v.wr = 1'b1; v.typ = typ; v.din = din;
        v.aw_dly = aw_dly; v.w_dly = w_dly; v.b_dly = b_dly;
        v.resp = resp; v.exp_strb = exp_strb;
        return v;
    endfunction

    // Drive one cache request and act as the AXI slave until it is acknowledged.
    task automatic run_txn(input int idx, input vec_t v);
        int acks, beat, gap, ar_wait, aw_wait, w_wait, b_wait, b_cyc;
        bit ar_acc, aw_n, w_n, b_done, done;
        acks = 0; beat = 0; gap = 0; b_cyc = -100;
        ar_wait = v.ar_dly; aw_wait = v.aw_dly; w_wait = v.w_dly; b_wait = v.b_dly;
        ar_acc = 0; aw_n = 0; w_n = 0; b_done = 0; done = 0;
        @(negedge clk);
        D_req = 1'b1; D_write = v.wr; D_addr = v.addr; D_in = v.din; D_type = v.typ;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            if (!v.wr && v.rst_after > 0 && acks == v.rst_after && RREADY) begin
                rst = 1'b1; D_req = 1'b0; RVALID = 1'b0; ARREADY = 1'b0;
                @(negedge clk);
                chk("rst_mid_valids", 32'({ARVALID, RREADY, AWVALID, WVALID, BREADY}), 32'd0);
                chk("rst_mid_dwait", 32'(D_wait), 32'd0);
                chk("rst_mid_dout", D_out, 32'd0);
                rst = 1'b0;
                done = 1;
                break;
            end
            if (D_req && !D_wait) begin
                if (v.wr) begin
                    chk("wr_ack_cycle", 32'(cyc), 32'(b_cyc + 1));
                    done = 1;
                end else begin
                    chk($sformatf("rd_word%0d", acks), D_out, v.rbase + 32'(acks));
                    acks++;
                    if (acks == BURST) done = 1;
                end
            end
            if (done) begin
                D_req = 1'b0; ARREADY = 1'b0; RVALID = 1'b0;
                AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0;
                break;
            end
            if (v.wr) begin
                if (aw_n) chk("awvalid_after_hs", 32'(AWVALID), 32'd0);
                if (w_n)  chk("wvalid_after_hs", 32'(WVALID), 32'd0);
                BVALID = 1'b0;
                if (aw_n && w_n && !b_done) begin
                    if (b_wait > 0) b_wait--;
                    else begin
                        BVALID = 1'b1; BRESP = v.resp;
                        if (BREADY) begin b_done = 1; b_cyc = cyc; end
                    end
                end
                AWREADY = 1'b0;
                if (AWVALID && !aw_n) begin
                    if (aw_wait > 0) aw_wait--;
                    else begin
                        AWREADY = 1'b1; aw_n = 1;
                        chk("awaddr", AWADDR, v.exp_axaddr);
                        chk("awlen_awsize_awid", 32'({AWLEN, AWSIZE, AWID}), 32'({4'd0, 3'b010, 4'd0}));
                    end
                end
                WREADY = 1'b0;
                if (WVALID && !w_n) begin
                    if (w_wait > 0) w_wait--;
                    else begin
                        WREADY = 1'b1; w_n = 1;
                        chk("wdata", WDATA, v.din);
                        chk("wstrb", 32'(WSTRB), 32'(v.exp_strb));
                        chk("wlast", 32'(WLAST), 32'd1);
                    end
                end
            end else begin
                if (ar_acc) chk("arvalid_after_hs", 32'(ARVALID), 32'd0);
                RVALID = 1'b0;
                if (ar_acc && beat < BURST) begin
                    if (gap > 0) gap--;
                    else begin
                        RVALID = 1'b1; RDATA = v.rbase + 32'(beat); RRESP = v.resp;
                        RLAST = v.rlast_rand ? 1'($urandom_range(0, 1)) : (beat == BURST - 1);
                        if (RREADY) begin
                            beat++;
                            gap = (beat == v.gap_beat) ? v.gap_len : 0;
                        end
                    end
                end
                ARREADY = 1'b0;
                if (ARVALID && !ar_acc) begin
                    if (ar_wait > 0) ar_wait--;
                    else begin
                        ARREADY = 1'b1; ar_acc = 1;
                        chk("araddr", ARADDR, v.exp_axaddr);
                        chk("arlen_arsize_arburst_arid", 32'({ARLEN, ARSIZE, ARBURST, ARID}),
                            32'({4'd3, 3'b010, 2'b01, 4'd0}));
                    end
                end
            end
        end
        chk("txn_complete", 32'(done), 32'd1);
        @(negedge clk);
        chk("idle_valids", 32'({ARVALID, AWVALID, WVALID}), 32'd0);
        $display("txn %0d: %s addr=0x%08h type=%0d acks=%0d", idx, v.wr ? "write" : "read",
                 v.addr, v.typ, v.wr ? 1 : acks);
    endtask

    vec_t        tbl[$];
    vec_t        v;
    logic [31:0] ra;
    logic [2:0]  rt;

    initial begin
        rst = 1'b1; D_req = 1'b0; D_write = 1'b0; D_addr = '0; D_in = '0; D_type = '0;
        ARREADY = 1'b0; RID = '0; RDATA = '0; RRESP = '0; RLAST = 1'b0; RVALID = 1'b0;
        AWREADY = 1'b0; WREADY = 1'b0; BID = '0; BRESP = '0; BVALID = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_valids", 32'({ARVALID, RREADY, AWVALID, WVALID, BREADY}), 32'd0);
        chk("reset_dout", D_out, 32'd0);
        chk("reset_dwait_noreq", 32'(D_wait), 32'd0);
        D_req = 1'b1;
        #1;
        chk("reset_dwait_req", 32'(D_wait), 32'd1);
        D_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors.
        tbl.push_back(rd_vec(32'h0000_1234, 32'h0000_00A0, 32'h0000_1230));
        tbl.push_back(wr_vec(32'h0000_2003, CACHE_BYTE, 32'hEF00_0000, 0, 0, 0, 2'b00, 4'b1000));
        tbl.push_back(wr_vec(32'h0000_2E02, CACHE_HWORD, 32'hBEEF_0000, 3, 0, 0, 2'b00, 4'b1100));
        v = rd_vec(32'h0000_5000, 32'h0000_00B0, 32'h0000_5000);
        v.gap_beat = 2; v.gap_len = 5;
        tbl.push_back(v);
        v = rd_vec(32'h0000_6000, 32'h0000_00C0, 32'h0000_6000);
        v.rst_after = 1;
        tbl.push_back(v);
        tbl.push_back(rd_vec(32'h0000_700C, 32'h0000_00D0, 32'h0000_7000));
        tbl.push_back(wr_vec(32'h0000_3000, CACHE_WORD, 32'h1234_5678, 0, 0, 1, 2'b10, 4'b1111));
        tbl.push_back(wr_vec(32'h0000_3004, CACHE_WORD, 32'h0BAD_F00D, 0, 0, 0, 2'b00, 4'b1111));
        tbl.push_back(wr_vec(32'h0000_4001, CACHE_BYTE_U, 32'h0000_5500, 0, 2, 0, 2'b00, 4'b0010));
        tbl.push_back(wr_vec(32'h0000_4000, CACHE_HWORD_U, 32'h0000_CAFE, 0, 0, 3, 2'b00, 4'b0011));
        tbl.push_back(wr_vec(32'h0000_4008, 3'd3, 32'h0101_0101, 1, 1, 0, 2'b00, 4'b0000));
        v = rd_vec(32'h0000_8FF8, 32'h0000_00E0, 32'h0000_8FF0);
        v.ar_dly = 2; v.rlast_rand = 1'b1;
        tbl.push_back(v);

        for (int i = 0; i < tbl.size(); i++) begin
`ifdef L1C_AXI_BRIDGE_ERR_EN
            if (i == 6) chk("err_clear_before", 32'(err_o), 32'd0);
`endif
            run_txn(i, tbl[i]);
        end
`ifdef L1C_AXI_BRIDGE_ERR_EN
        chk("err_sticky", 32'(err_o), 32'd1);
        chk("err_addr", err_addr, 32'h0000_3000);
`endif

        // Randomized transactions against the reference rules.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rt = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                v = wr_vec(ra, rt, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                           $urandom_range(0, 3), 2'($urandom_range(0, 3)), model_strb(rt, ra));
            end else begin
                v = rd_vec(ra, $urandom, ra & ~32'hF);
                v.ar_dly = $urandom_range(0, 3);
                v.gap_beat = $urandom_range(1, 3);
                v.gap_len = $urandom_range(0, 4);
                v.rlast_rand = 1'b1;
                v.resp = 2'($urandom_range(0, 3));
            end
            run_txn(100 + i, v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
